oh_cgate_ctrl: RTL and testbench



---
 rtl/oh_cgate_ctrl.sv | 114 +++++++++++
 tb/tb_oh_cgate_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/oh_cgate_ctrl.sv
// Idle-detect clock-gate controller: registered enable for a downstream latch+AND gate.
// Latency: gate_en drops on the edge taking the cfg_idle-th idle sample; rises one edge after a wake cause.
// Backpressure: none; wake_req is a level request answered by a one-cycle wake_ack.
//
// Ports:
//   clk, nreset      free-running clock, async active-low reset
//   cfg_en, cfg_idle gating enable and idle threshold (cfg_idle==0 disables gating)
//   activity         downstream busy; wake_req/wake_ack level request / one-cycle ack
//   gate_en, gated   registered enable and GATED status
//   stat_gated       gated-cycle counter, built only with OH_CGATE_STATS_EN (else tied 0)
module oh_cgate_ctrl #(
  parameter int IDLEW   = 8,
  parameter int WAKEDLY = 2
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             cfg_en,
  input  logic [IDLEW-1:0] cfg_idle,
  input  logic             activity,
  input  logic             wake_req,
  output logic             wake_ack,
  output logic             gate_en,
  output logic             gated,
  output logic [31:0]      stat_gated
);

  typedef enum logic [1:0] {ST_ACTIVE, ST_GATED, ST_WAKE} state_t;

  state_t           state_q;
  logic [IDLEW-1:0] idle_cnt_q;
  logic [7:0]       wake_cnt_q;
  logic             gate_en_q;
  logic             gated_q;
  logic             wake_ack_q;

  logic             idle;
  logic             wake_cause;
  logic             thr_hit;
  logic [IDLEW-1:0] idle_cnt_d;

  assign idle       = cfg_en & (cfg_idle != '0) & ~activity & ~wake_req;
  assign wake_cause = activity | wake_req | ~cfg_en | (cfg_idle == '0);
  // Extra bit keeps the +1 from wrapping when the counter sits at all-ones.
  assign thr_hit    = ({1'b0, idle_cnt_q} + {{IDLEW{1'b0}}, 1'b1}) >= {1'b0, cfg_idle};
  assign idle_cnt_d = (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + 1'b1;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= ST_ACTIVE;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      gate_en_q  <= 1'b1;
      gated_q    <= 1'b0;
      wake_ack_q <= 1'b0;
    end else begin
      wake_ack_q <= (state_q == ST_ACTIVE) & wake_req & ~wake_ack_q;
      case (state_q)
        ST_ACTIVE: begin
          if (!idle) begin
            idle_cnt_q <= '0;
          end else if (thr_hit) begin
            state_q    <= ST_GATED;
            gate_en_q  <= 1'b0;
            gated_q    <= 1'b1;
            idle_cnt_q <= '0;
          end else begin
            idle_cnt_q <= idle_cnt_d;
          end
        end
        ST_GATED: begin
          if (wake_cause) begin
            state_q    <= ST_WAKE;
            gate_en_q  <= 1'b1;
            gated_q    <= 1'b0;
            wake_cnt_q <= '0;
          end
        end
        ST_WAKE: begin
          // Enable is already high; hold here WAKEDLY cycles regardless of inputs.
          wake_cnt_q <= wake_cnt_q + 8'd1;
          if (wake_cnt_q == 8'(WAKEDLY - 1)) begin
            state_q <= ST_ACTIVE;
          end
        end
        default: begin
          state_q   <= ST_ACTIVE;
          gate_en_q <= 1'b1;
          gated_q   <= 1'b0;
        end
      endcase
    end
  end

  assign gate_en  = gate_en_q;
  assign gated    = gated_q;
  assign wake_ack = wake_ack_q;

`ifdef OH_CGATE_STATS_EN
  logic [31:0] stat_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      stat_q <= '0;
    end else if ((state_q == ST_GATED) && (stat_q != 32'hFFFF_FFFF)) begin
      stat_q <= stat_q + 32'd1;
    end
  end

  assign stat_gated = stat_q;
`else
  assign stat_gated = '0;
`endif

endmodule

// File: tb/tb_oh_cgate_ctrl.sv
module tb_oh_cgate_ctrl;

  logic        clk;
  logic        nreset;
  logic        cfg_en;
  logic [7:0]  cfg_idle;
  logic        activity;
  logic        wake_req;
  logic        wake_ack;
  logic        gate_en;
  logic        gated;
  logic [31:0] stat_gated;

  int errors = 0;
  int checks = 0;

`ifdef OH_CGATE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  oh_cgate_ctrl #(.IDLEW(8), .WAKEDLY(2)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .cfg_en     (cfg_en),
    .cfg_idle   (cfg_idle),
    .activity   (activity),
    .wake_req   (wake_req),
    .wake_ack   (wake_ack),
    .gate_en    (gate_en),
    .gated      (gated),
    .stat_gated (stat_gated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; outputs of that edge are then stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bit saw_low;
    nreset   = 1'b0;
    cfg_en   = 1'b1;
    cfg_idle = 8'd4;
    activity = 1'b1;
    wake_req = 1'b0;
    #12;
    chk("rst_gate_en", {31'd0, gate_en}, 32'd1);
    chk("rst_gated", {31'd0, gated}, 32'd0);
    chk("rst_wake_ack", {31'd0, wake_ack}, 32'd0);
    chk("rst_stat", stat_gated, 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    ticks(3);

    // Idle count with an activity pulse restarting it.
    activity = 1'b0;
    ticks(2);
    activity = 1'b1;
    tick();
    activity = 1'b0;
    ticks(3);
    chk("idle3_gate_en", {31'd0, gate_en}, 32'd1);
    tick();
    chk("idle4_gate_en", {31'd0, gate_en}, 32'd0);
    chk("idle4_gated", {31'd0, gated}, 32'd1);

    // Gated for 50 edges, then one-cycle activity wake.
    ticks(50);
    chk("stat_50", stat_gated, STATS ? 32'd50 : 32'd0);
    activity = 1'b1;
    tick();
    activity = 1'b0;
    chk("act_wake_gate_en", {31'd0, gate_en}, 32'd1);
    chk("act_wake_gated", {31'd0, gated}, 32'd0);
    tick();
    chk("wake1_gate_en", {31'd0, gate_en}, 32'd1);
    tick();
    ticks(3);
    chk("fresh_cnt3", {31'd0, gate_en}, 32'd1);
    tick();
    chk("fresh_cnt4", {31'd0, gate_en}, 32'd0);

    // wake_req from GATED, held until acked.
    wake_req = 1'b1;
    tick();
    chk("req_wake_gate_en", {31'd0, gate_en}, 32'd1);
    chk("req_wake_ack0", {31'd0, wake_ack}, 32'd0);
    ticks(2);
    chk("req_active_ack0", {31'd0, wake_ack}, 32'd0);
    tick();
    chk("req_ack1", {31'd0, wake_ack}, 32'd1);
    wake_req = 1'b0;
    tick();
    chk("req_drop_ack0a", {31'd0, wake_ack}, 32'd0);
    tick();
    chk("req_drop_ack0b", {31'd0, wake_ack}, 32'd0);
    wake_req = 1'b1;
    tick();
    chk("hold_ack1", {31'd0, wake_ack}, 32'd1);
    tick();
    chk("hold_ack_gap", {31'd0, wake_ack}, 32'd0);
    tick();
    chk("hold_ack2", {31'd0, wake_ack}, 32'd1);
    chk("hold_gate_en", {31'd0, gate_en}, 32'd1);
    wake_req = 1'b0;

    // cfg_idle==0 then cfg_en==0: never gates.
    cfg_idle = 8'd0;
    saw_low = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (!gate_en) saw_low = 1'b1;
    end
    chk("idle0_never_gates", {31'd0, saw_low}, 32'd0);
    cfg_idle = 8'd4;
    cfg_en   = 1'b0;
    saw_low  = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (!gate_en) saw_low = 1'b1;
    end
    chk("en0_never_gates", {31'd0, saw_low}, 32'd0);

    // Clearing cfg_en while gated wakes on the next edge.
    cfg_en = 1'b1;
    ticks(4);
    chk("en_gate", {31'd0, gate_en}, 32'd0);
    cfg_en = 1'b0;
    tick();
    chk("en_clear_wake", {31'd0, gate_en}, 32'd1);
    chk("en_clear_gated", {31'd0, gated}, 32'd0);
    ticks(3);

    // Threshold lowered below the running count gates on the next idle sample.
    cfg_en   = 1'b1;
    cfg_idle = 8'd8;
    ticks(5);
    chk("thr8_cnt5", {31'd0, gate_en}, 32'd1);
    cfg_idle = 8'd3;
    tick();
    chk("thr_lowered", {31'd0, gate_en}, 32'd0);

    // Async reset while gated, mid-cycle.
    cfg_idle = 8'd4;
    #2;
    nreset = 1'b0;
    #1;
    chk("async_gate_en", {31'd0, gate_en}, 32'd1);
    chk("async_gated", {31'd0, gated}, 32'd0);
    chk("async_stat", stat_gated, 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    ticks(3);
    chk("post_rst_cnt3", {31'd0, gate_en}, 32'd1);
    tick();
    chk("post_rst_cnt4", {31'd0, gate_en}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
